// File: rtl/countdown_scheduler.sv
// Round-robin scheduler that lends one shared down-counter to N_REQ requesters.
// Each grant loads the winner's count, ticks down on en, and pulses done to the owner at zero.
module countdown_scheduler #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*CNT_W-1:0] load_val,
    input  logic                   en,
    output logic [N_REQ-1:0]       grant,
    output logic                   busy,
    output logic [CNT_W-1:0]       cnt_out,
    output logic [N_REQ-1:0]       done,
    output logic [1:0]             dbg_state
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COUNT, S_DONE} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   owner, ptr, win, owner_inc, idx_w;
    logic [CNT_W-1:0] cnt;
    logic            any_req, owner_req, abort, found;
    int              idx;

    // First requester at or after the pointer, wrapping modulo N_REQ.
    always_comb begin
        win   = ptr;
        found = 1'b0;
        idx   = 0;
        idx_w = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx   = (int'(ptr) + i) % N_REQ;
            idx_w = IW'(idx);
            if (!found && req[idx_w]) begin
                win   = idx_w;
                found = 1'b1;
            end
        end
    end

    assign any_req   = |req;
    assign owner_req = req[owner];
    assign owner_inc = (owner == IW'(N_REQ - 1)) ? '0 : owner + IW'(1);
    // Dropping the owner's request wins over a completion in the same cycle.
    assign abort     = ((state == S_LOAD) || (state == S_COUNT)) && !owner_req;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (any_req) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = abort ? S_IDLE : S_COUNT;
            S_COUNT: begin
                if (abort)                    state_nxt = S_IDLE;
                else if (en && cnt == '0)     state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= '1;
            owner <= '0;
            ptr   <= '0;
        end else begin
            if (state == S_IDLE && any_req) begin
                owner <= win;
                cnt   <= load_val[int'(win)*CNT_W +: CNT_W];
            end
            if (state == S_COUNT && !abort && en && cnt != '0)
                cnt <= cnt - CNT_W'(1);
            if (abort || state == S_DONE)
                ptr <= owner_inc;
        end
    end

    always_comb begin
        grant     = '0;
        done      = '0;
        busy      = 1'b0;
        dbg_state = state;
        if (state != S_IDLE) begin
            grant[owner] = 1'b1;
            busy         = 1'b1;
        end
        if (state == S_DONE) done[owner] = 1'b1;
    end

    assign cnt_out = cnt;

endmodule

// File: tb/tb_countdown_scheduler.sv
// Directed bench for countdown_scheduler: expected done pulses are queued at stimulus time
// and a negedge monitor pops and compares them; cycle-level values are checked inline.
module tb_countdown_scheduler;

    localparam int N_REQ = 4;
    localparam int CNT_W = 8;
    localparam logic [1:0] ST_IDLE = 2'd0, ST_LOAD = 2'd1, ST_COUNT = 2'd2, ST_DONE = 2'd3;

    logic                   clk;
    logic                   reset;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*CNT_W-1:0] load_val;
    logic                   en;
    logic [N_REQ-1:0]       grant;
    logic                   busy;
    logic [CNT_W-1:0]       cnt_out;
    logic [N_REQ-1:0]       done;
    logic [1:0]             dbg_state;

    logic [N_REQ-1:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    countdown_scheduler #(.N_REQ(N_REQ), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .req(req), .load_val(load_val), .en(en),
        .grant(grant), .busy(busy), .cnt_out(cnt_out), .done(done), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_load(input int i, input logic [CNT_W-1:0] v);
        load_val[i*CNT_W +: CNT_W] = v;
    endtask

    task automatic wait_state(input logic [1:0] s, input int limit);
        int k;
        k = 0;
        while (dbg_state !== s && k < limit) begin
            tick();
            k++;
        end
        check("wait_state", {30'd0, dbg_state}, {30'd0, s});
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    // scoreboard monitor: every done pulse must match the oldest expected entry
    always @(negedge clk) begin
        if (done !== '0) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_done: got %b expected none", done);
            end else begin
                logic [N_REQ-1:0] e;
                e = exp_q.pop_front();
                if (done !== e) begin
                    n_bad++;
                    $display("FAIL done_pulse: got %b expected %b", done, e);
                end
            end
        end
    end

    initial begin
        int exp_cnt[7];
        logic [N_REQ-1:0] rr_order[6];
        exp_cnt  = '{2, 2, 1, 1, 0, 0, 0};
        rr_order = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};

        req = '0; load_val = '0; en = 1'b0; reset = 1'b1;
        #2 reset = 1'b0;

        // reset state, then hold after release
        tick(); tick();
        check("rst_grant", grant, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_cnt", cnt_out, 8'hFF);
        reset = 1'b1;
        tick(); tick(); tick();
        check("idle_cnt_hold", cnt_out, 8'hFF);
        check("idle_grant", grant, 0);
        check("idle_busy", busy, 0);

        // single request, load 3
        set_load(1, 8'd3);
        en = 1'b1;
        exp_q.push_back(4'b0010);
        req = 4'b0010;
        tick();
        check("single_grant", grant, 4'b0010);
        check("single_load_cnt", cnt_out, 3);
        check("single_load_state", dbg_state, ST_LOAD);
        for (int v = 3; v >= 0; v--) begin
            tick();
            check("single_cnt", cnt_out, v);
        end
        tick();
        check("single_done_state", dbg_state, ST_DONE);
        check("single_done_grant", grant, 4'b0010);
        req = '0;
        tick();
        check("single_after_grant", grant, 0);
        check("single_after_cnt", cnt_out, 0);

        // round robin from a fresh pointer
        pulse_reset();
        load_val = '0;
        for (int i = 0; i < 6; i++) exp_q.push_back(rr_order[i]);
        req = 4'b1011;
        for (int i = 0; i < 6; i++) begin
            wait_state(ST_LOAD, 8);
            check("rr_grant", grant, rr_order[i]);
            wait_state(ST_DONE, 8);
            if (i == 5) req = '0;
        end
        wait_state(ST_IDLE, 4);
        tick();
        check("rr_idle_busy", busy, 0);

        // en gating: requester 0, load 2
        set_load(0, 8'd2);
        en = 1'b0;
        exp_q.push_back(4'b0001);
        req = 4'b0001;
        tick();
        check("gate_grant", grant, 4'b0001);
        check("gate_load_cnt", cnt_out, 2);
        for (int i = 0; i < 7; i++) begin
            en = (i % 2 == 0);
            tick();
            check("gate_cnt", cnt_out, exp_cnt[i]);
            check("gate_state", dbg_state, (i == 6) ? ST_DONE : ST_COUNT);
        end
        req = '0; en = 1'b0;
        tick();
        check("gate_idle", busy, 0);

        // abort: owner 2 dropped at 6, requester 3 follows
        set_load(2, 8'd10);
        set_load(3, 8'd1);
        en = 1'b1;
        exp_q.push_back(4'b1000);
        req = 4'b1100;
        tick();
        check("abort_grant", grant, 4'b0100);
        check("abort_load_cnt", cnt_out, 10);
        for (int v = 10; v >= 6; v--) begin
            tick();
            check("abort_cnt", cnt_out, v);
        end
        req = 4'b1000;
        tick();
        check("abort_grant_clr", grant, 0);
        check("abort_busy", busy, 0);
        check("abort_cnt_kept", cnt_out, 6);
        tick();
        check("abort_next_grant", grant, 4'b1000);
        check("abort_next_cnt", cnt_out, 1);
        wait_state(ST_DONE, 8);
        req = '0;
        tick();

        // reset mid-count
        set_load(2, 8'd20);
        req = 4'b0100;
        tick();
        check("midrst_grant", grant, 4'b0100);
        for (int v = 20; v >= 12; v--) begin
            tick();
            check("midrst_cnt", cnt_out, v);
        end
        reset = 1'b0;
        #1;
        check("midrst_cnt_ff", cnt_out, 8'hFF);
        check("midrst_grant_clr", grant, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        tick(); tick();
        reset = 1'b1;
        tick();
        check("midrst_regrant", grant, 4'b0100);
        check("midrst_reload", cnt_out, 20);
        req = '0;
        tick();
        check("midrst_abort_idle", busy, 0);
        check("midrst_abort_cnt", cnt_out, 20);

        tick(); tick();
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
